// File: rtl/matvec_engine_if.sv
// Handshake and bus bundle for matvec_engine: start/mode, coefficient write
// port, x input stream, y result stream and status flags.
interface matvec_engine_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int N      = 4,
  parameter int M      = 4
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(N);
  localparam int AW    = $clog2(M * N);
  localparam int RW    = $clog2(M);

  logic              start_in;
  logic              signed_mode;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              valid_input;
  logic [DATA_W-1:0] X_load;
  logic              x_ready;
  logic              y_valid;
  logic              y_ready;
  logic [ACC_W-1:0]  y_data;
  logic [RW-1:0]     y_row;
  logic              busy;
  logic              finish;

  // Driver side: the loader / consumer environment.
  modport master (
    output start_in, signed_mode, coef_we, coef_addr, coef_data,
           valid_input, X_load, y_ready,
    input  x_ready, y_valid, y_data, y_row, busy, finish
  );

  // Engine side.
  modport slave (
    input  start_in, signed_mode, coef_we, coef_addr, coef_data,
           valid_input, X_load, y_ready,
    output x_ready, y_valid, y_data, y_row, busy, finish
  );
endinterface

// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: y = A*x with an MxN coefficient store,
// one MAC per cycle, signed/unsigned operands and a valid/ready result
// stream. All outputs are registered.
module matvec_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int N      = 4,
  parameter int M      = 4
) (
  input  logic           clk,
  input  logic           rst,
  matvec_engine_if.slave bus
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(N);
  localparam int AW    = $clog2(M * N);
  localparam int CW    = $clog2(N);
  localparam int RW    = $clog2(M);

  typedef enum logic [2:0] {IDLE, LOAD_X, MAC, OUT, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ACC_W-1:0]  acc_q;
  logic              signed_q;
  logic [DATA_W-1:0] x_q    [N];
  logic [COEF_W-1:0] coef_q [M*N];

  logic              x_ready_q;
  logic              y_valid_q;
  logic [ACC_W-1:0]  y_data_q;
  logic [RW-1:0]     y_row_q;
  logic              busy_q;
  logic              finish_q;

  logic              coef_wr_en;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] x_cur;
  logic [COEF_W-1:0] c_cur;
  logic [ACC_W-1:0]  x_ext;
  logic [ACC_W-1:0]  c_ext;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_d;

  logic              last_col;
  logic              last_row;

  assign last_col = (col_q == CW'(N - 1));
  assign last_row = (row_q == RW'(M - 1));

  // Coefficients may only change while idle; addresses past M*N are dropped.
  assign coef_wr_en = (state_q == IDLE) && bus.coef_we &&
                      ({1'b0, bus.coef_addr} < (AW + 1)'(M * N));

  // Flattened coefficient address of A[row][col].
  assign rd_idx = AW'(row_q) * AW'(N) + AW'(col_q);
  assign x_cur  = x_q[col_q];
  assign c_cur  = coef_q[rd_idx];

  // Extend both operands to the accumulator width; the low ACC_W bits of the
  // product are then correct for both signed and unsigned operation.
  assign x_ext = signed_q ? {{(ACC_W - DATA_W){x_cur[DATA_W-1]}}, x_cur}
                          : {{(ACC_W - DATA_W){1'b0}}, x_cur};
  assign c_ext = signed_q ? {{(ACC_W - COEF_W){c_cur[COEF_W-1]}}, c_cur}
                          : {{(ACC_W - COEF_W){1'b0}}, c_cur};
  assign prod  = x_ext * c_ext;
  assign acc_d = acc_q + prod;

  // Coefficient store: persists across runs, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < M * N; i++) coef_q[i] <= '0;
    end else if (coef_wr_en) begin
      coef_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      signed_q  <= 1'b0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_row_q   <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            signed_q  <= bus.signed_mode;
            col_q     <= '0;
            row_q     <= '0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (bus.valid_input && x_ready_q) begin
            x_q[col_q] <= bus.X_load;
            if (last_col) begin
              col_q     <= '0;
              acc_q     <= '0;
              x_ready_q <= 1'b0;
              state_q   <= MAC;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (last_col) begin
            col_q     <= '0;
            y_valid_q <= 1'b1;
            y_data_q  <= acc_d;
            y_row_q   <= row_q;
            state_q   <= OUT;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        OUT: begin
          // y_data/y_row are only reloaded on entry, so they hold under stall.
          if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            if (last_row) begin
              finish_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              row_q   <= row_q + 1'b1;
              col_q   <= '0;
              acc_q   <= '0;
              state_q <= MAC;
            end
          end
        end
        DONE: begin
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_ready = x_ready_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_row   = y_row_q;
  assign bus.busy    = busy_q;
  assign bus.finish  = finish_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Scoreboard bench for matvec_engine: directed runs push hand-computed
// results into a queue, an independent monitor pops and compares on every
// y handshake and also watches hold-under-stall and finish timing.
module tb_matvec_engine;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int N      = 4;
  localparam int M      = 4;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(N);
  localparam int AW     = $clog2(M * N);
  localparam int RW     = $clog2(M);

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   last_hs_cyc;

  logic [RW+ACC_W-1:0] exp_q [$];
  logic [RW+ACC_W-1:0] mon_e;
  logic                prev_v;
  logic                prev_r;
  logic [ACC_W-1:0]    prev_d;
  logic [RW-1:0]       prev_row;

  matvec_engine_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .N(N), .M(M)) bus ();

  matvec_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int row, input int val);
    logic [ACC_W-1:0] d;
    logic [RW-1:0]    r;
    d = ACC_W'(val);
    r = RW'(row);
    exp_q.push_back({r, d});
  endtask

  task automatic write_coef(input int addr, input int val);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(addr);
    bus.coef_data = COEF_W'(val);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  // mode 0: identity, 1: fill with val, 2: A[r][c] = r*N+c+1
  task automatic load_matrix(input int mode, input int val);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        case (mode)
          0: write_coef(r * N + c, (r == c) ? 1 : 0);
          1: write_coef(r * N + c, val);
          default: write_coef(r * N + c, r * N + c + 1);
        endcase
  endtask

  task automatic push_seq_golden();
    // x = 1,2,3,4 against rows (1..4),(5..8),(9..12),(13..16)
    push_exp(0, 30);
    push_exp(1, 70);
    push_exp(2, 110);
    push_exp(3, 150);
  endtask

  // One run. Entered and left at #1 after a rising edge with the DUT idle.
  task automatic run_case(input bit smode, input logic [N*DATA_W-1:0] xv,
                          input bit gaps, input int stall_row, input int stall_len,
                          input bit inject, input int rst_row);
    int  i, k, hs, stall_left, last_x;
    bit  acc_now, first_seen, done, aborted, saw_fin;
    bus.y_ready     = 1'b1;
    bus.signed_mode = smode;
    bus.start_in    = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("x_ready_after_start", bus.x_ready, 1);

    i = 0; k = 0; last_x = 0;
    while (i < N && k < 100) begin
      acc_now = 1'b0;
      if (gaps && (k % 2 == 1)) begin
        bus.valid_input = 1'b0;
      end else begin
        bus.valid_input = 1'b1;
        bus.X_load      = xv[i*DATA_W +: DATA_W];
        if (bus.x_ready) begin
          acc_now = 1'b1;
          last_x  = cyc;
        end
      end
      @(posedge clk); #1;
      if (acc_now) i++;
      k++;
    end
    bus.valid_input = 1'b0;
    if (i < N) check("x_load_timeout", 0, 1);

    hs = 0; k = 0; stall_left = stall_len;
    first_seen = 1'b0; done = 1'b0; aborted = 1'b0;
    while (!done && k < 300) begin
      if (bus.finish) begin
        done = 1'b1;
        bus.start_in = 1'b0; bus.coef_we = 1'b0; bus.valid_input = 1'b0;
      end else if (rst_row >= 0 && hs == rst_row && bus.busy && !bus.y_valid && !bus.x_ready) begin
        bus.start_in = 1'b0; bus.coef_we = 1'b0; bus.valid_input = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_x_ready", bus.x_ready, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_y_data", bus.y_data, 0);
        check("rst_y_row", bus.y_row, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_finish", bus.finish, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        saw_fin = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          saw_fin = saw_fin | bus.finish;
        end
        check("no_finish_after_rst", saw_fin, 0);
        check("idle_after_rst", bus.busy, 0);
        done = 1'b1;
        aborted = 1'b1;
      end else begin
        if (!first_seen && bus.y_valid) begin
          first_seen = 1'b1;
          check("first_y_latency", cyc - last_x, N + 1);
        end
        if (bus.y_valid && int'(bus.y_row) == stall_row && stall_left > 0) begin
          bus.y_ready = 1'b0;
          stall_left--;
        end else begin
          bus.y_ready = 1'b1;
        end
        if (inject && bus.busy && !bus.x_ready) begin
          bus.start_in    = 1'b1;
          bus.coef_we     = 1'b1;
          bus.coef_addr   = '0;
          bus.coef_data   = COEF_W'(9);
          bus.valid_input = 1'b1;
          bus.X_load      = DATA_W'(77);
        end else begin
          bus.start_in = 1'b0; bus.coef_we = 1'b0; bus.valid_input = 1'b0;
        end
        if (bus.y_valid && bus.y_ready) hs++;
        @(posedge clk); #1;
        k++;
      end
    end
    bus.y_ready = 1'b1;
    if (!done) check("finish_timeout", 0, 1);
    if (!aborted && done) begin
      check("handshake_count", hs, M);
      check("busy_in_done", bus.busy, 1);
      @(posedge clk); #1;
      check("finish_one_cycle", bus.finish, 0);
      check("busy_cleared", bus.busy, 0);
    end
    if (stall_len > 0) check("stall_applied", stall_left, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: compares every accepted result against the scoreboard.
  initial begin
    prev_v = 1'b0; prev_r = 1'b1; prev_d = '0; prev_row = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
        prev_r = 1'b1;
      end else begin
        if (prev_v && !prev_r) begin
          check("stall_hold_valid", bus.y_valid, 1);
          check("stall_hold_data", bus.y_data, prev_d);
          check("stall_hold_row", bus.y_row, prev_row);
        end
        if (bus.y_valid && bus.y_ready) begin
          $display("y handshake row=%0d data=%0d cyc=%0d", bus.y_row, bus.y_data, cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_y", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("y_row", bus.y_row, mon_e[ACC_W +: RW]);
            check("y_data", bus.y_data, mon_e[ACC_W-1:0]);
          end
          if (int'(bus.y_row) == M - 1) last_hs_cyc = cyc;
        end
        if (bus.finish) check("finish_after_last_hs", cyc - last_hs_cyc, 1);
        prev_v   = bus.y_valid;
        prev_r   = bus.y_ready;
        prev_d   = bus.y_data;
        prev_row = bus.y_row;
      end
    end
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; last_hs_cyc = -100;
    rst = 1'b0;
    bus.start_in = 1'b0; bus.signed_mode = 1'b0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_data = '0; bus.valid_input = 1'b0;
    bus.X_load = '0; bus.y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x_ready", bus.x_ready, 0);
    check("reset_y_valid", bus.y_valid, 0);
    check("reset_y_data", bus.y_data, 0);
    check("reset_y_row", bus.y_row, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_finish", bus.finish, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);

    // Identity, unsigned
    load_matrix(0, 0);
    push_exp(0, 1); push_exp(1, 2); push_exp(2, 3); push_exp(3, 4);
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, -1);

    // Unsigned extremes: 4 * 255 * 255
    load_matrix(1, 255);
    for (int r = 0; r < M; r++) push_exp(r, 260100);
    run_case(1'b0, {4{8'hFF}}, 1'b0, -1, 0, 1'b0, -1);

    // Signed extremes: 4 * (-128) * (-128)
    load_matrix(1, 8'h80);
    for (int r = 0; r < M; r++) push_exp(r, 65536);
    run_case(1'b1, {4{8'h80}}, 1'b0, -1, 0, 1'b0, -1);

    // Signed mixed: row 0 = -1,1,-1,1; rows 1..3 still -128
    write_coef(0, 8'hFF); write_coef(1, 1); write_coef(2, 8'hFF); write_coef(3, 1);
    push_exp(0, 2);
    for (int r = 1; r < M; r++) push_exp(r, -1280);
    run_case(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, -1);

    // Sequential matrix: no-stall golden, then gaps + 5-cycle stall on row 1
    load_matrix(2, 0);
    push_seq_golden();
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, -1);
    push_seq_golden();
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1, 5, 1'b0, -1);

    // Ignored start/coef_we/valid_input during MAC and OUT, then clean rerun
    push_seq_golden();
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b1, -1);
    push_seq_golden();
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, -1);

    // Reset during row 2 MAC; rows 0,1 already delivered
    push_exp(0, 30); push_exp(1, 70);
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, 2);

    // Coefficient store was cleared by reset
    for (int r = 0; r < M; r++) push_exp(r, 0);
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, -1);

    // Reload and rerun against golden
    load_matrix(2, 0);
    push_seq_golden();
    run_case(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, -1, 0, 1'b0, -1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
